reorder_buffer: RTL and testbench

- In-order retirement buffer between rename/dispatch and the free pool / architectural register file.
- One entry allocated per renamed instruction in program order; functional units mark entries complete out of order; the head retires in order.
- On retirement of a register-writing instruction, the superseded physical tag (rd_old_tag) is pushed back to the free pool. This is the producer end of the free pool's push_free_reg/freed_reg interface.

---
 rtl/reorder_buffer_pkg.sv | 26 ++
 rtl/reorder_buffer_rob_entry_ram.sv | 71 +++++++
 rtl/reorder_buffer.sv | 176 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: field widths and the ROB entry payload.
// Imported by rename, the free pool, the reservation stations and the ROB itself.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned IDX_WIDTH  = 4;
  localparam int unsigned PREG_WIDTH = 6;
  localparam int unsigned AREG_WIDTH = 5;
  localparam int unsigned PC_WIDTH   = 12;
  localparam int unsigned CNT_WIDTH  = IDX_WIDTH + 1;

  // Payload stored per ROB entry; valid/complete bits live beside it in the RAM.
  typedef struct packed {
    logic                  reg_write;
    logic [AREG_WIDTH-1:0] areg_rd;
    logic [PREG_WIDTH-1:0] preg_rd;
    logic [PREG_WIDTH-1:0] old_preg;
    logic [PC_WIDTH-1:0]   pc;
  } rob_entry_t;

  // Ring-pointer increment; wraps naturally because ROB_DEPTH is 2**IDX_WIDTH.
  function automatic logic [IDX_WIDTH-1:0] idx_inc(input logic [IDX_WIDTH-1:0] idx);
    return idx + IDX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_entry_ram.sv
// ROB entry storage: ROB_DEPTH-entry register array with valid/complete bits.
// Ports:
//   clk, rst                  clock, synchronous active-high reset (clears valid/complete)
//   wr_en/wr_idx/wr_data      allocation write (valid=1, complete=0, payload)
//   set0_*/set1_*             completion ports, set complete only on valid entries
//   clr_en/clr_idx            retirement clear of valid and complete
//   rd_idx                    asynchronous read address (head)
//   rd_valid_c/rd_complete_c/rd_data_c  combinational read data
module rob_entry_ram
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  rob_entry_t           wr_data,
  input  logic                 set0_en,
  input  logic [IDX_WIDTH-1:0] set0_idx,
  input  logic                 set1_en,
  input  logic [IDX_WIDTH-1:0] set1_idx,
  input  logic                 clr_en,
  input  logic [IDX_WIDTH-1:0] clr_idx,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic                 rd_valid_c,
  output logic                 rd_complete_c,
  output rob_entry_t           rd_data_c
);

  logic [ROB_DEPTH-1:0]                valid_q, valid_d;
  logic [ROB_DEPTH-1:0]                complete_q, complete_d;
  rob_entry_t [ROB_DEPTH-1:0]          mem_q, mem_d;

  // Update order: completion sets, then retire clear, then allocation write,
  // so a write into a slot cleared this cycle wins over the clear.
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    mem_d      = mem_q;
    if (set0_en && valid_q[set0_idx]) complete_d[set0_idx] = 1'b1;
    if (set1_en && valid_q[set1_idx]) complete_d[set1_idx] = 1'b1;
    if (clr_en) begin
      valid_d[clr_idx]    = 1'b0;
      complete_d[clr_idx] = 1'b0;
    end
    if (wr_en) begin
      valid_d[wr_idx]    = 1'b1;
      complete_d[wr_idx] = 1'b0;
      mem_d[wr_idx]      = wr_data;
    end
  end

  // Status bits reset; payload is qualified by valid and needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      complete_q <= '0;
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_valid_c    = valid_q[rd_idx];
  assign rd_complete_c = complete_q[rd_idx];
  assign rd_data_c     = mem_q[rd_idx];

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation from rename, out-of-order completion
// from two FU ports, in-order retirement with superseded-tag return to the
// free pool.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   alloc_*                      allocation handshake, payload and assigned index (tail)
//   cmpl0_*/cmpl1_*              completion ports
//   fp_full                      free pool cannot accept a push (stalls reg-writing retire)
//   retire_*                     registered retirement pulse and ARF commit data
//   push_free_reg/freed_reg      registered free-pool push of the superseded tag
//   count/empty/full             occupancy
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic                  alloc_reg_write,
  input  logic [AREG_WIDTH-1:0] alloc_areg_rd,
  input  logic [PREG_WIDTH-1:0] alloc_preg_rd,
  input  logic [PREG_WIDTH-1:0] alloc_old_preg,
  input  logic [PC_WIDTH-1:0]   alloc_pc,
  output logic [IDX_WIDTH-1:0]  alloc_idx,
  input  logic                  cmpl0_valid,
  input  logic [IDX_WIDTH-1:0]  cmpl0_idx,
  input  logic                  cmpl1_valid,
  input  logic [IDX_WIDTH-1:0]  cmpl1_idx,
  input  logic                  fp_full,
  output logic                  retire_valid,
  output logic [AREG_WIDTH-1:0] retire_areg,
  output logic [PREG_WIDTH-1:0] retire_preg,
  output logic [PC_WIDTH-1:0]   retire_pc,
  output logic                  push_free_reg,
  output logic [PREG_WIDTH-1:0] freed_reg,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full
);

  logic [IDX_WIDTH-1:0]  head_q, head_d;
  logic [IDX_WIDTH-1:0]  tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  alloc_ready_q, alloc_ready_d;

  logic                  retire_valid_q, retire_valid_d;
  logic [AREG_WIDTH-1:0] retire_areg_q, retire_areg_d;
  logic [PREG_WIDTH-1:0] retire_preg_q, retire_preg_d;
  logic [PC_WIDTH-1:0]   retire_pc_q, retire_pc_d;
  logic                  push_free_reg_q, push_free_reg_d;
  logic [PREG_WIDTH-1:0] freed_reg_q, freed_reg_d;

  logic                  alloc_fire_c;
  logic                  retire_fire_c;
  logic                  head_valid_c;
  logic                  head_complete_c;
  rob_entry_t            head_entry_c;
  rob_entry_t            alloc_entry_c;

  always_comb begin
    alloc_entry_c           = '0;
    alloc_entry_c.reg_write = alloc_reg_write;
    alloc_entry_c.areg_rd   = alloc_areg_rd;
    alloc_entry_c.preg_rd   = alloc_preg_rd;
    alloc_entry_c.old_preg  = alloc_old_preg;
    alloc_entry_c.pc        = alloc_pc;
  end

  rob_entry_ram u_ram (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (alloc_fire_c),
    .wr_idx        (tail_q),
    .wr_data       (alloc_entry_c),
    .set0_en       (cmpl0_valid),
    .set0_idx      (cmpl0_idx),
    .set1_en       (cmpl1_valid),
    .set1_idx      (cmpl1_idx),
    .clr_en        (retire_fire_c),
    .clr_idx       (head_q),
    .rd_idx        (head_q),
    .rd_valid_c    (head_valid_c),
    .rd_complete_c (head_complete_c),
    .rd_data_c     (head_entry_c)
  );

  // Handshake: ready comes from registered occupancy only, never from a same-cycle retire.
  // Retire stalls only when the head would push into a full free pool.
  always_comb begin
    alloc_fire_c  = alloc_valid & alloc_ready_q;
    retire_fire_c = head_valid_c & head_complete_c
                    & ~(head_entry_c.reg_write & fp_full);
  end

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (retire_fire_c) head_d = idx_inc(head_q);
    if (alloc_fire_c)  tail_d = idx_inc(tail_q);
    case ({alloc_fire_c, retire_fire_c})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    full_d        = (count_d == CNT_WIDTH'(ROB_DEPTH));
    empty_d       = (count_d == '0);
    alloc_ready_d = ~full_d;
  end

  // Retirement outputs: pulses each retire, data holds between retires.
  always_comb begin
    retire_valid_d  = retire_fire_c;
    retire_areg_d   = retire_areg_q;
    retire_preg_d   = retire_preg_q;
    retire_pc_d     = retire_pc_q;
    push_free_reg_d = 1'b0;
    freed_reg_d     = freed_reg_q;
    if (retire_fire_c) begin
      retire_areg_d = head_entry_c.areg_rd;
      retire_preg_d = head_entry_c.preg_rd;
      retire_pc_d   = head_entry_c.pc;
      // Physical tag 0 is reserved and never returned to the pool.
      if (head_entry_c.reg_write && (head_entry_c.old_preg != '0)) begin
        push_free_reg_d = 1'b1;
        freed_reg_d     = head_entry_c.old_preg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      alloc_ready_q   <= 1'b1;
      retire_valid_q  <= 1'b0;
      retire_areg_q   <= '0;
      retire_preg_q   <= '0;
      retire_pc_q     <= '0;
      push_free_reg_q <= 1'b0;
      freed_reg_q     <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      full_q          <= full_d;
      empty_q         <= empty_d;
      alloc_ready_q   <= alloc_ready_d;
      retire_valid_q  <= retire_valid_d;
      retire_areg_q   <= retire_areg_d;
      retire_preg_q   <= retire_preg_d;
      retire_pc_q     <= retire_pc_d;
      push_free_reg_q <= push_free_reg_d;
      freed_reg_q     <= freed_reg_d;
    end
  end

  assign alloc_ready   = alloc_ready_q;
  assign alloc_idx     = tail_q;
  assign count         = count_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign retire_valid  = retire_valid_q;
  assign retire_areg   = retire_areg_q;
  assign retire_preg   = retire_preg_q;
  assign retire_pc     = retire_pc_q;
  assign push_free_reg = push_free_reg_q;
  assign freed_reg     = freed_reg_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a program-order queue model plus
// directed scenarios and a randomized phase.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic                  alloc_reg_write;
  logic [AREG_WIDTH-1:0] alloc_areg_rd;
  logic [PREG_WIDTH-1:0] alloc_preg_rd;
  logic [PREG_WIDTH-1:0] alloc_old_preg;
  logic [PC_WIDTH-1:0]   alloc_pc;
  logic [IDX_WIDTH-1:0]  alloc_idx;
  logic                  cmpl0_valid;
  logic [IDX_WIDTH-1:0]  cmpl0_idx;
  logic                  cmpl1_valid;
  logic [IDX_WIDTH-1:0]  cmpl1_idx;
  logic                  fp_full;
  logic                  retire_valid;
  logic [AREG_WIDTH-1:0] retire_areg;
  logic [PREG_WIDTH-1:0] retire_preg;
  logic [PC_WIDTH-1:0]   retire_pc;
  logic                  push_free_reg;
  logic [PREG_WIDTH-1:0] freed_reg;
  logic [CNT_WIDTH-1:0]  count;
  logic                  empty;
  logic                  full;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_reg_write(alloc_reg_write), .alloc_areg_rd(alloc_areg_rd),
    .alloc_preg_rd(alloc_preg_rd), .alloc_old_preg(alloc_old_preg),
    .alloc_pc(alloc_pc), .alloc_idx(alloc_idx),
    .cmpl0_valid(cmpl0_valid), .cmpl0_idx(cmpl0_idx),
    .cmpl1_valid(cmpl1_valid), .cmpl1_idx(cmpl1_idx),
    .fp_full(fp_full),
    .retire_valid(retire_valid), .retire_areg(retire_areg),
    .retire_preg(retire_preg), .retire_pc(retire_pc),
    .push_free_reg(push_free_reg), .freed_reg(freed_reg),
    .count(count), .empty(empty), .full(full)
  );

  // Model: in-flight instructions in program order; front is the head.
  typedef struct {
    logic [3:0]  idx;
    logic        rw;
    logic [4:0]  areg;
    logic [5:0]  preg;
    logic [5:0]  old;
    logic [11:0] pc;
    bit          cmp;
  } ment_t;

  ment_t       mq[$];
  int          m_tail = 0;
  logic        e_rv = 1'b0, e_push = 1'b0;
  logic [4:0]  e_areg = '0;
  logic [5:0]  e_preg = '0, e_freed = '0;
  logic [11:0] e_pc = '0;

  logic [5:0]  ret_log[$];
  logic [5:0]  free_log[$];
  logic [11:0] pc_log[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input bit chk_freed);
    chk("retire_valid",  32'(retire_valid),  32'(e_rv));
    chk("push_free_reg", 32'(push_free_reg), 32'(e_push));
    chk("retire_areg",   32'(retire_areg),   32'(e_areg));
    chk("retire_preg",   32'(retire_preg),   32'(e_preg));
    chk("retire_pc",     32'(retire_pc),     32'(e_pc));
    if (chk_freed || e_push) chk("freed_reg", 32'(freed_reg), 32'(e_freed));
    chk("count",       32'(count),       32'(mq.size()));
    chk("empty",       32'(empty),       32'(mq.size() == 0));
    chk("full",        32'(full),        32'(mq.size() == 16));
    chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() != 16));
    chk("alloc_idx",   32'(alloc_idx),   32'(m_tail));
    if (retire_valid === 1'b1) begin
      ret_log.push_back(retire_preg);
      pc_log.push_back(retire_pc);
    end
    if (push_free_reg === 1'b1) free_log.push_back(freed_reg);
  endtask

  // One clock: model decisions from pre-edge state and inputs, then compare #1 after the edge.
  task automatic tick();
    bit    ret, af;
    ment_t h, n;
    if (rst) begin
      @(posedge clk); #1;
      mq.delete();
      m_tail = 0;
      e_rv = 1'b0; e_push = 1'b0; e_areg = '0; e_preg = '0; e_pc = '0; e_freed = '0;
      check_all(1'b1);
      return;
    end
    ret = (mq.size() > 0) && mq[0].cmp && !(mq[0].rw && fp_full);
    af  = alloc_valid && (mq.size() < 16);
    @(posedge clk); #1;
    for (int i = 0; i < mq.size(); i++)
      if ((cmpl0_valid && mq[i].idx == cmpl0_idx) || (cmpl1_valid && mq[i].idx == cmpl1_idx))
        mq[i].cmp = 1'b1;
    if (ret) begin
      h = mq.pop_front();
      e_rv = 1'b1; e_areg = h.areg; e_preg = h.preg; e_pc = h.pc;
      e_push = h.rw && (h.old != 0);
      if (e_push) e_freed = h.old;
    end else begin
      e_rv = 1'b0; e_push = 1'b0;
    end
    if (af) begin
      n.idx = 4'(m_tail); n.rw = alloc_reg_write; n.areg = alloc_areg_rd;
      n.preg = alloc_preg_rd; n.old = alloc_old_preg; n.pc = alloc_pc; n.cmp = 1'b0;
      mq.push_back(n);
      m_tail = (m_tail + 1) % 16;
    end
    check_all(1'b0);
  endtask

  task automatic set_alloc(input bit v, input bit rw, input logic [4:0] a,
                           input logic [5:0] p, input logic [5:0] o, input logic [11:0] pc);
    alloc_valid = v; alloc_reg_write = rw; alloc_areg_rd = a;
    alloc_preg_rd = p; alloc_old_preg = o; alloc_pc = pc;
  endtask

  task automatic rand_alloc(input bit v);
    set_alloc(v, 1'($urandom_range(0, 1)), 5'($urandom), 6'($urandom), 6'($urandom), 12'($urandom));
  endtask

  function automatic bit in_q(input logic [3:0] t);
    foreach (mq[i]) if (mq[i].idx == t) return 1'b1;
    return 1'b0;
  endfunction

  // Completion pick: mostly an incomplete in-flight entry, sometimes an invalid slot.
  task automatic pick_cmpl(output logic v, output logic [3:0] idx);
    int          r;
    int          cand[$];
    logic [3:0]  t;
    v = 1'b0; idx = '0;
    r = $urandom_range(0, 99);
    foreach (mq[i]) if (!mq[i].cmp) cand.push_back(i);
    if (r < 60 && cand.size() > 0) begin
      v = 1'b1; idx = mq[cand[$urandom_range(0, cand.size() - 1)]].idx;
    end else if (r < 70) begin
      t = 4'($urandom_range(0, 15));
      if (!in_q(t) && t != 4'(m_tail)) begin v = 1'b1; idx = t; end
    end
  endtask

  task automatic no_cmpl();
    cmpl0_valid = 1'b0; cmpl1_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    alloc_valid = 1'b0; fp_full = 1'b0;
    for (int c = 0; c < 200 && mq.size() > 0; c++) begin
      no_cmpl();
      k = 0;
      foreach (mq[i]) if (!mq[i].cmp) begin
        if (k == 0) begin cmpl0_valid = 1'b1; cmpl0_idx = mq[i].idx; end
        else if (k == 1) begin cmpl1_valid = 1'b1; cmpl1_idx = mq[i].idx; end
        k++;
      end
      tick();
    end
    no_cmpl();
    tick(); tick();
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  hidx;
    logic [11:0] wr_pcs[$];
    logic        v;
    logic [3:0]  ix;

    rst = 1'b1; fp_full = 1'b0;
    set_alloc(1'b0, 1'b0, '0, '0, '0, '0);
    no_cmpl(); cmpl0_idx = '0; cmpl1_idx = '0;
    tick(); tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    rst = 1'b0;

    // Three allocations completed in reverse order retire in program order.
    ret_log.delete(); free_log.delete();
    for (int k = 0; k < 3; k++) begin
      set_alloc(1'b1, 1'b1, 5'(k + 1), 6'(33 + k), (k == 2) ? 6'd0 : 6'(k + 1), 12'(100 + k));
      tick();
    end
    alloc_valid = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      cmpl0_valid = 1'b1; cmpl0_idx = 4'(k);
      tick();
    end
    no_cmpl();
    // Completion of idx0 lands on the last edge above; retire on the next edge.
    tick();
    chk("order_first_retire_latency", 32'(retire_valid), 32'd1);
    repeat (4) tick();
    chk("order_n_retired", 32'(ret_log.size()), 32'd3);
    chk("order_preg0", 32'(ret_log[0]), 32'd33);
    chk("order_preg1", 32'(ret_log[1]), 32'd34);
    chk("order_preg2", 32'(ret_log[2]), 32'd35);
    chk("order_n_freed", 32'(free_log.size()), 32'd2);
    chk("order_freed0", 32'(free_log[0]), 32'd1);
    chk("order_freed1", 32'(free_log[1]), 32'd2);

    // Fill to capacity; a 17th request is refused.
    for (int k = 0; k < 16; k++) begin
      rand_alloc(1'b1); alloc_reg_write = 1'b0;
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(alloc_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd16);
    rand_alloc(1'b1);
    tick();
    chk("fill_17th_tail", 32'(alloc_idx), 32'd3);
    chk("fill_17th_count", 32'(count), 32'd16);
    alloc_valid = 1'b0;
    cmpl0_valid = 1'b1; cmpl0_idx = 4'd3;
    tick();
    no_cmpl();
    chk("fill_full_before_retire", 32'(full), 32'd1);
    tick();
    chk("fill_full_after_retire", 32'(full), 32'd0);
    chk("fill_count_after_retire", 32'(count), 32'd15);
    drain();

    // Free-pool back-pressure holds a reg-writing head.
    fp_full = 1'b1;
    hidx = 4'(m_tail);
    set_alloc(1'b1, 1'b1, 5'd9, 6'd40, 6'd7, 12'h5A5);
    tick();
    alloc_valid = 1'b0;
    cmpl0_valid = 1'b1; cmpl0_idx = hidx;
    tick();
    no_cmpl();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_held", 32'(retire_valid), 32'd0);
    end
    fp_full = 1'b0;
    tick();
    chk("bp_release_valid", 32'(retire_valid), 32'd1);
    chk("bp_release_push", 32'(push_free_reg), 32'd1);
    chk("bp_release_freed", 32'(freed_reg), 32'd7);
    chk("bp_release_pc", 32'(retire_pc), 32'h5A5);
    drain();

    // Sustained stream across pointer wrap.
    pc_log.delete();
    hidx = '0;
    for (int k = 0; k < 44; k++) begin
      no_cmpl();
      if (k >= 1 && k <= 40) begin cmpl0_valid = 1'b1; cmpl0_idx = hidx; end
      if (k < 40) begin
        rand_alloc(1'b1);
        wr_pcs.push_back(alloc_pc);
        hidx = 4'(m_tail);
      end else begin
        alloc_valid = 1'b0;
      end
      tick();
      if (k == 20) chk("wrap_steady_count", 32'(count), 32'd2);
    end
    chk("wrap_n_retired", 32'(pc_log.size()), 32'd40);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 40 && k < pc_log.size(); k++)
        if (pc_log[k] !== wr_pcs[k]) bad++;
      chk("wrap_pc_sequence_errors", 32'(bad), 32'd0);
    end
    drain();

    // Randomized traffic with back-pressure and shared completion indices.
    for (int c = 0; c < 800; c++) begin
      rand_alloc(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
      fp_full = ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0;
      pick_cmpl(v, ix); cmpl0_valid = v; cmpl0_idx = ix;
      if ($urandom_range(0, 3) == 0) begin
        cmpl1_valid = cmpl0_valid; cmpl1_idx = cmpl0_idx;
      end else begin
        pick_cmpl(v, ix); cmpl1_valid = v; cmpl1_idx = ix;
      end
      tick();
    end
    no_cmpl();
    drain();

    // Reset with five in flight, two non-head entries complete.
    for (int k = 0; k < 5; k++) begin
      set_alloc(1'b1, 1'b1, 5'(k), 6'(20 + k), 6'(10 + k), 12'(k));
      tick();
    end
    alloc_valid = 1'b0;
    cmpl0_valid = 1'b1; cmpl0_idx = mq[2].idx;
    cmpl1_valid = 1'b1; cmpl1_idx = mq[3].idx;
    tick();
    no_cmpl();
    rst = 1'b1;
    tick();
    chk("midrst_no_retire", 32'(retire_valid), 32'd0);
    chk("midrst_no_push", 32'(push_free_reg), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_no_retire_after", 32'(retire_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
